// File: rtl/VX_axi_pkg.sv
// Shared AXI read-channel types for the read arbiter slice.
// Address, ID and data widths are parameters of the users, so they stay outside these structs.
package VX_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [1:0] lock;
      logic [3:0] cache;
      logic [2:0] prot;
      logic [3:0] qos;
      logic [3:0] region;
   } ar_req_t;

   typedef struct packed {
      logic [1:0] resp;
      logic       last;
   } r_rsp_t;

endpackage

// File: rtl/VX_axi_rd_credit.sv
// Per-input open-burst counter: +1 on AR handshake, -1 on last R beat, saturating at 0 and MAX.
module VX_axi_rd_credit #(
   parameter  int MAX_OUTSTANDING = 8,
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             zero
);

   assign full = (cnt == CNT_W'(MAX_OUTSTANDING));
   assign zero = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec && !full) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/VX_elastic_buffer.sv
// 2-entry elastic buffer: registered ready, one-cycle latency, full throughput, stable head.
module VX_elastic_buffer #(
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [DATAW-1:0] data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [DATAW-1:0] data_out
);

   logic [1:0][DATAW-1:0] mem;
   logic                  rd_ptr, wr_ptr;
   logic [1:0]            count;
   logic                  push, pop;

   assign ready_in  = (count != 2'd2);
   assign valid_out = (count != 2'd0);
   assign data_out  = mem[rd_ptr];
   assign push      = valid_in && ready_in;
   assign pop       = valid_out && ready_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vx_axi_read_arb_multi.sv
// N-to-1 AXI4 read arbiter: round-robin AR with per-input burst limits, source index tagged into ARID,
// R beats routed back by that tag. Sticky error on beats nobody is waiting for.
module vx_axi_read_arb_multi
   import VX_axi_pkg::*;
#(
   parameter  int NUM_INPUTS      = 4,
   parameter  int MAX_OUTSTANDING = 8,
   parameter  int TAG_SEL_IDX     = 0,
   parameter  int AXI_DATA_WIDTH  = 512,
   parameter  int AXI_ADDR_WIDTH  = 32,
   parameter  int AXI_TID_WIDTH   = 4,
   localparam int SEL_BITS        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
   localparam int SEL_W           = (SEL_BITS > 0) ? SEL_BITS : 1,
   localparam int OUT_TID_WIDTH   = AXI_TID_WIDTH + SEL_BITS
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_INPUTS-1:0]                    s_arvalid,
   output logic [NUM_INPUTS-1:0]                    s_arready,
   input  logic [NUM_INPUTS-1:0][AXI_ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_INPUTS-1:0][AXI_TID_WIDTH-1:0] s_arid,
   input  logic [NUM_INPUTS-1:0][7:0]               s_arlen,
   input  logic [NUM_INPUTS-1:0][2:0]               s_arsize,
   input  logic [NUM_INPUTS-1:0][1:0]               s_arburst,
   input  logic [NUM_INPUTS-1:0][1:0]               s_arlock,
   input  logic [NUM_INPUTS-1:0][3:0]               s_arcache,
   input  logic [NUM_INPUTS-1:0][2:0]               s_arprot,
   input  logic [NUM_INPUTS-1:0][3:0]               s_arqos,
   input  logic [NUM_INPUTS-1:0][3:0]               s_arregion,
   output logic [NUM_INPUTS-1:0]                    s_rvalid,
   input  logic [NUM_INPUTS-1:0]                    s_rready,
   output logic [NUM_INPUTS-1:0][AXI_DATA_WIDTH-1:0] s_rdata,
   output logic [NUM_INPUTS-1:0]                    s_rlast,
   output logic [NUM_INPUTS-1:0][AXI_TID_WIDTH-1:0] s_rid,
   output logic [NUM_INPUTS-1:0][1:0]               s_rresp,
   output logic                                     m_arvalid,
   input  logic                                     m_arready,
   output logic [OUT_TID_WIDTH-1:0]                 m_arid,
   output logic [AXI_ADDR_WIDTH-1:0]                m_araddr,
   output logic [7:0]                               m_arlen,
   output logic [2:0]                               m_arsize,
   output logic [1:0]                               m_arburst,
   output logic [1:0]                               m_arlock,
   output logic [3:0]                               m_arcache,
   output logic [2:0]                               m_arprot,
   output logic [3:0]                               m_arqos,
   output logic [3:0]                               m_arregion,
   input  logic                                     m_rvalid,
   output logic                                     m_rready,
   input  logic [AXI_DATA_WIDTH-1:0]                m_rdata,
   input  logic                                     m_rlast,
   input  logic [OUT_TID_WIDTH-1:0]                 m_rid,
   input  logic [1:0]                               m_rresp,
   output logic                                     idle,
   output logic                                     err_unexp_rsp,
   output logic [SEL_W-1:0]                         err_src
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int AR_W  = OUT_TID_WIDTH + AXI_ADDR_WIDTH + $bits(ar_req_t);
   localparam int R_W   = OUT_TID_WIDTH + AXI_DATA_WIDTH + $bits(r_rsp_t);

   logic [NUM_INPUTS-1:0][CNT_W-1:0] cnt;
   logic [NUM_INPUTS-1:0]            cnt_full, cnt_zero, eligible, grant, r_last_hs;
   logic [SEL_W-1:0]                 ptr, win_idx;
   logic                             any_grant, ar_buf_ready;
   int                               idx;
   logic [OUT_TID_WIDTH-1:0]         tagged_id;
   ar_req_t                          win_attr, m_attr;

   assign eligible  = s_arvalid & ~cnt_full;
   assign s_arready = grant & {NUM_INPUTS{ar_buf_ready}};

   // First eligible input at or after the priority pointer, wrapping around.
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
         if (!any_grant && eligible[idx]) begin
            any_grant  = 1'b1;
            grant[idx] = 1'b1;
            win_idx    = SEL_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (any_grant && ar_buf_ready) begin
         ptr <= (int'(win_idx) == NUM_INPUTS - 1) ? '0 : win_idx + 1'b1;
      end
   end

   // Source index spliced into the ID at TAG_SEL_IDX; higher ID bits shift up.
   always_comb begin
      tagged_id = '0;
      for (int b = 0; b < OUT_TID_WIDTH; b++) begin
         if (b < TAG_SEL_IDX)                 tagged_id[b] = s_arid[win_idx][b];
         else if (b < TAG_SEL_IDX + SEL_BITS) tagged_id[b] = win_idx[b - TAG_SEL_IDX];
         else                                 tagged_id[b] = s_arid[win_idx][b - SEL_BITS];
      end
      win_attr = '{len:    s_arlen[win_idx],   size:  s_arsize[win_idx],
                   burst:  s_arburst[win_idx], lock:  s_arlock[win_idx],
                   cache:  s_arcache[win_idx], prot:  s_arprot[win_idx],
                   qos:    s_arqos[win_idx],   region: s_arregion[win_idx]};
   end

   VX_elastic_buffer #(.DATAW(AR_W)) ar_buf (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (any_grant),
      .ready_in  (ar_buf_ready),
      .data_in   ({tagged_id, s_araddr[win_idx], win_attr}),
      .valid_out (m_arvalid),
      .ready_out (m_arready),
      .data_out  ({m_arid, m_araddr, m_attr})
   );

   assign m_arlen    = m_attr.len;
   assign m_arsize   = m_attr.size;
   assign m_arburst  = m_attr.burst;
   assign m_arlock   = m_attr.lock;
   assign m_arcache  = m_attr.cache;
   assign m_arprot   = m_attr.prot;
   assign m_arqos    = m_attr.qos;
   assign m_arregion = m_attr.region;

   logic                      rb_valid, rb_ready, sel_ok, err_evt;
   logic [OUT_TID_WIDTH-1:0]  rb_id;
   logic [AXI_DATA_WIDTH-1:0] rb_data;
   r_rsp_t                    rb_rsp;
   logic [SEL_W-1:0]          rsel;
   logic [AXI_TID_WIDTH-1:0]  rb_orig_id;

   VX_elastic_buffer #(.DATAW(R_W)) r_buf (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (m_rvalid),
      .ready_in  (m_rready),
      .data_in   ({m_rid, m_rdata, m_rresp, m_rlast}),
      .valid_out (rb_valid),
      .ready_out (rb_ready),
      .data_out  ({rb_id, rb_data, rb_rsp})
   );

   always_comb begin
      rsel       = '0;
      rb_orig_id = '0;
      for (int b = 0; b < SEL_BITS; b++) rsel[b] = rb_id[TAG_SEL_IDX + b];
      for (int b = 0; b < AXI_TID_WIDTH; b++) begin
         rb_orig_id[b] = (b < TAG_SEL_IDX) ? rb_id[b] : rb_id[b + SEL_BITS];
      end
      sel_ok = (int'(rsel) < NUM_INPUTS);
      // Beats tagged for a nonexistent input are popped immediately and dropped.
      rb_ready = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         s_rvalid[i]  = rb_valid && sel_ok && (int'(rsel) == i);
         s_rdata[i]   = rb_data;
         s_rlast[i]   = rb_rsp.last;
         s_rid[i]     = rb_orig_id;
         s_rresp[i]   = rb_rsp.resp;
         r_last_hs[i] = s_rvalid[i] && s_rready[i] && rb_rsp.last;
         if (int'(rsel) == i) rb_ready = s_rready[i];
      end
      err_evt = rb_valid && !sel_ok;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (s_rvalid[i] && s_rready[i] && cnt_zero[i]) err_evt = 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_credit
      VX_axi_rd_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) credit (
         .clk   (clk),
         .reset (reset),
         .inc   (s_arvalid[i] && s_arready[i]),
         .dec   (r_last_hs[i]),
         .cnt   (cnt[i]),
         .full  (cnt_full[i]),
         .zero  (cnt_zero[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_unexp_rsp <= 1'b0;
         err_src       <= '0;
      end else if (err_evt && !err_unexp_rsp) begin
         err_unexp_rsp <= 1'b1;
         err_src       <= rsel;
      end
   end

   assign idle = (&cnt_zero) && !m_arvalid && !rb_valid;

endmodule

// File: tb/tb_vx_axi_read_arb_multi.sv
// Scoreboard bench for the read arbiter: AR and R expectations are queued as stimulus is accepted.
module tb_vx_axi_read_arb_multi;

   localparam int N   = 4;
   localparam int MO  = 2;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int TW  = 4;
   localparam int OTW = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [N-1:0]          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [N-1:0][AW-1:0]  s_araddr;
   logic [N-1:0][TW-1:0]  s_arid, s_rid;
   logic [N-1:0][7:0]     s_arlen;
   logic [N-1:0][2:0]     s_arsize, s_arprot;
   logic [N-1:0][1:0]     s_arburst, s_arlock, s_rresp;
   logic [N-1:0][3:0]     s_arcache, s_arqos, s_arregion;
   logic [N-1:0][DW-1:0]  s_rdata;
   logic                  m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [OTW-1:0]        m_arid, m_rid;
   logic [AW-1:0]         m_araddr;
   logic [7:0]            m_arlen;
   logic [2:0]            m_arsize, m_arprot;
   logic [1:0]            m_arburst, m_arlock, m_rresp;
   logic [3:0]            m_arcache, m_arqos, m_arregion;
   logic [DW-1:0]         m_rdata;
   logic                  idle, err_unexp_rsp;
   logic [1:0]            err_src;

   vx_axi_read_arb_multi #(
      .NUM_INPUTS(N), .MAX_OUTSTANDING(MO), .TAG_SEL_IDX(0),
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_TID_WIDTH(TW)
   ) dut (
      .clk(clk), .reset(reset),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
      .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
      .s_rid(s_rid), .s_rresp(s_rresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
      .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos), .m_arregion(m_arregion),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .m_rid(m_rid), .m_rresp(m_rresp),
      .idle(idle), .err_unexp_rsp(err_unexp_rsp), .err_src(err_src)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [63:0] exp_ar[$];
   logic [39:0] exp_r[$];
   logic [38:0] inj_q[$];
   int          grant_log[$];
   int          gcyc[$];
   int          ar_rem[N];
   int          ar_seq[N];
   int          ar_hs_cyc[N];
   int          sr_hs_cyc[N];
   int          cyc = 0;
   int          mr_cyc = 0;
   int          first_mar = -1;
   logic [N-1:0] ar_hs, sr_hs;
   logic         mar_hs, mr_hs;

   function automatic logic [TW-1:0] f_id(input int i, input int s);
      return TW'((i * 3 + s) & 15);
   endfunction

   function automatic logic [AW-1:0] f_addr(input int i, input int s);
      return AW'(32'h1000 * i + s * 64);
   endfunction

   task automatic inj(input logic [3:0] id, input logic [1:0] sel, input logic last,
                      input logic [31:0] data);
      inj_q.push_back({id, sel, last, data});
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         s_arvalid[i]  = (ar_rem[i] > 0);
         s_araddr[i]   = f_addr(i, ar_seq[i]);
         s_arid[i]     = f_id(i, ar_seq[i]);
         s_arlen[i]    = 8'(ar_seq[i]);
         s_arsize[i]   = 3'd2;
         s_arburst[i]  = 2'b01;
         s_arlock[i]   = 2'b00;
         s_arcache[i]  = 4'h3;
         s_arprot[i]   = 3'd0;
         s_arqos[i]    = 4'(i);
         s_arregion[i] = 4'h0;
      end
      if (!m_rvalid || mr_hs) begin
         if (inj_q.size() > 0) begin
            m_rvalid = 1'b1;
            {m_rid, m_rlast, m_rdata} = inj_q.pop_front();
         end else begin
            m_rvalid = 1'b0;
         end
      end
      mr_hs = 1'b0;
   endtask

   task automatic cycle();
      logic [63:0] e;
      logic [39:0] er;
      int d;
      #1;
      ar_hs  = s_arvalid & s_arready;
      mar_hs = m_arvalid && m_arready;
      mr_hs  = m_rvalid && m_rready;
      sr_hs  = s_rvalid & s_rready;
      for (int i = 0; i < N; i++) begin
         if (ar_hs[i]) begin
            exp_ar.push_back(64'({f_id(i, ar_seq[i]), 2'(i), f_addr(i, ar_seq[i]),
                                  8'(ar_seq[i]), 4'(i)}));
            grant_log.push_back(i);
            gcyc.push_back(cyc);
            ar_hs_cyc[i] = cyc;
         end
      end
      if (mar_hs) begin
         if (first_mar < 0) first_mar = cyc;
         if (exp_ar.size() == 0) check("m_ar_unexpected", 64'(m_arid), 64'hFFFF);
         else begin
            e = exp_ar.pop_front();
            check("m_ar", 64'({m_arid, m_araddr, m_arlen, m_arqos}), e);
         end
      end
      if (mr_hs) begin
         exp_r.push_back({3'(m_rid[1:0]), m_rid[5:2], m_rlast, m_rdata});
         mr_cyc = cyc;
      end
      if (sr_hs != '0) begin
         d = 0;
         for (int i = 0; i < N; i++) if (sr_hs[i]) d = i;
         if ($countones(sr_hs) != 1) check("s_r_onehot", 64'(sr_hs), 64'(1 << d));
         sr_hs_cyc[d] = cyc;
         if (exp_r.size() == 0) check("s_r_unexpected", 64'(s_rdata[d]), 64'hFFFF);
         else begin
            er = exp_r.pop_front();
            check("s_r", 64'({3'(d), s_rid[d], s_rlast[d], s_rdata[d]}), 64'(er));
         end
      end
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (ar_hs[i]) begin
            ar_rem[i]--;
            ar_seq[i]++;
         end
      end
      drive();
   endtask

   task automatic drain(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) ar_rem[i] = 0;
      s_arvalid = '0;
      m_rvalid  = 1'b0;
      mr_hs     = 1'b0;
      inj_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      s_rready  = '1;
      m_arready = 1'b1;
      m_rvalid  = 1'b0;
      m_rid     = '0;
      m_rdata   = '0;
      m_rlast   = 1'b0;
      m_rresp   = 2'b00;
      for (int i = 0; i < N; i++) begin
         ar_seq[i] = 0;
         ar_hs_cyc[i] = 0;
         sr_hs_cyc[i] = 0;
      end
      do_reset();
      drive();
      #1;
      check("rst_m_arvalid", 64'(m_arvalid), 0);
      check("rst_s_arready", 64'(s_arready), 0);
      check("rst_s_rvalid", 64'(s_rvalid), 0);
      check("rst_m_rready", 64'(m_rready), 1);
      check("rst_idle", 64'(idle), 1);
      check("rst_err", 64'({err_unexp_rsp, err_src}), 0);

      // Round-robin with all four inputs requesting
      for (int i = 0; i < N; i++) ar_rem[i] = 2;
      drive();
      drain(12);
      check("grant_count", 64'(grant_log.size()), 8);
      for (int k = 0; k < grant_log.size() && k < 8; k++)
         check($sformatf("grant_%0d", k), 64'(grant_log[k]), 64'(k % 4));
      if (gcyc.size() == 8) check("ar_throughput", 64'(gcyc[7] - gcyc[0]), 7);
      if (gcyc.size() > 0) check("ar_latency", 64'(first_mar - gcyc[0]), 1);
      for (int i = 0; i < N; i++) check($sformatf("cnt_full_%0d", i), 64'(dut.cnt[i]), MO);

      // Outstanding limit on input 1, released by one last beat
      ar_rem[1] = 1;
      drive();
      repeat (3) begin
         cycle();
         check("held_arready1", 64'(s_arready[1]), 0);
      end
      inj(4'h9, 2'd1, 1'b1, 32'hA1A1_0001);
      drive();
      drain(5);
      check("limit_reissue", 64'(ar_hs_cyc[1] - sr_hs_cyc[1]), 1);
      check("cnt1_refill", 64'(dut.cnt[1]), MO);

      // Four-beat burst for input 2, id 5
      inj(4'h5, 2'd2, 1'b0, 32'hD000_0000);
      drive();
      cycle();
      cycle();
      check("r_latency", 64'(sr_hs_cyc[2] - mr_cyc), 1);
      inj(4'h5, 2'd2, 1'b0, 32'hD000_0001);
      inj(4'h5, 2'd2, 1'b0, 32'hD000_0002);
      drive();
      drain(5);
      check("cnt2_mid_burst", 64'(dut.cnt[2]), 2);
      inj(4'h5, 2'd2, 1'b1, 32'hD000_0003);
      drive();
      drain(4);
      check("cnt2_after_last", 64'(dut.cnt[2]), 1);

      // Back-pressure from input 3 with input 0 beats queued behind
      s_rready[3] = 1'b0;
      for (int k = 0; k < 4; k++) inj(4'hC, 2'd3, k == 3, 32'hB300_0000 + k);
      inj(4'h1, 2'd0, 1'b0, 32'hB000_0000);
      inj(4'h1, 2'd0, 1'b1, 32'hB000_0001);
      drive();
      drain(6);
      check("bp_m_rready", 64'(m_rready), 0);
      check("bp_s_rvalid", 64'(s_rvalid), 64'b1000);
      s_rready[3] = 1'b1;
      drain(12);
      check("cnt3_after_bp", 64'(dut.cnt[3]), 1);
      check("cnt0_after_bp", 64'(dut.cnt[0]), 1);

      inj(4'h1, 2'd0, 1'b1, 32'hC000_0000);
      inj(4'h2, 2'd1, 1'b1, 32'hC000_0001);
      inj(4'h3, 2'd1, 1'b1, 32'hC000_0002);
      inj(4'h4, 2'd2, 1'b1, 32'hC000_0003);
      inj(4'h6, 2'd3, 1'b1, 32'hC000_0004);
      drive();
      drain(12);
      for (int i = 0; i < N; i++) check($sformatf("cnt_drained_%0d", i), 64'(dut.cnt[i]), 0);
      check("idle_drained", 64'(idle), 1);
      check("no_err_yet", 64'(err_unexp_rsp), 0);

      // AR and last-beat handshakes on input 0 in the same cycle
      ar_rem[0] = 1;
      drive();
      drain(3);
      check("cnt0_one", 64'(dut.cnt[0]), 1);
      inj(4'h7, 2'd0, 1'b1, 32'hE000_0000);
      drive();
      cycle();
      ar_rem[0] = 1;
      drive();
      cycle();
      check("simul_hs", 64'({ar_hs[0], sr_hs[0]}), 64'b11);
      check("cnt0_simul", 64'(dut.cnt[0]), 1);
      inj(4'h7, 2'd0, 1'b1, 32'hE000_0001);
      drive();
      drain(6);
      check("cnt0_final", 64'(dut.cnt[0]), 0);
      check("idle_final", 64'(idle), 1);
      check("no_err_simul", 64'(err_unexp_rsp), 0);

      // Unexpected response after reset
      do_reset();
      drive();
      #1;
      check("rst2_err", 64'(err_unexp_rsp), 0);
      @(negedge clk);
      inj(4'h3, 2'd1, 1'b1, 32'hF000_0001);
      drive();
      drain(5);
      check("unexp_err", 64'(err_unexp_rsp), 1);
      check("unexp_src", 64'(err_src), 1);
      inj(4'h2, 2'd3, 1'b1, 32'hF000_0003);
      drive();
      drain(5);
      check("unexp_sticky", 64'(err_unexp_rsp), 1);
      check("unexp_src_first", 64'(err_src), 1);
      do_reset();
      drive();
      #1;
      check("err_cleared", 64'({err_unexp_rsp, err_src}), 0);

      check("ar_sb_empty", 64'(exp_ar.size()), 0);
      check("r_sb_empty", 64'(exp_r.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
